// File: rtl/bit_index_decoder.sv
// Rebuilds an N-bit vector from a framed stream of bit-index beats and holds it until taken downstream.
// Optional macro BIT_INDEX_DECODER_DUP_FLAG_EN adds out_dup, flagging frames that hit an already-set bit.
module bit_index_decoder #(
    parameter  int N  = 32,
    localparam int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rstb,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [IW-1:0] in_idx,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_vec,
    output logic [IW:0]   out_count
`ifdef BIT_INDEX_DECODER_DUP_FLAG_EN
    ,
    output logic          out_dup
`endif
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [IW:0] N_W = (IW+1)'(N);

    state_t        state_q, state_d;
    logic [N-1:0]  acc_q, acc_d;
    logic [IW:0]   cnt_q, cnt_d;
    logic          live_q;
    logic          hold;
    logic          in_fire;
    logic          in_range;
    logic          hit;
    logic [N-1:0]  bit_oh;
`ifdef BIT_INDEX_DECODER_DUP_FLAG_EN
    logic          dup_q, dup_d;
`endif

    // live_q keeps in_ready low until the first edge after reset releases
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            live_q  <= 1'b0;
`ifdef BIT_INDEX_DECODER_DUP_FLAG_EN
            dup_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            live_q  <= 1'b1;
`ifdef BIT_INDEX_DECODER_DUP_FLAG_EN
            dup_q   <= dup_d;
`endif
        end
    end

    assign hold     = (state_q == HOLD);
    assign in_ready = ~hold & live_q;
    assign in_fire  = in_valid & in_ready;
    assign in_range = ({1'b0, in_idx} < N_W);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        bit_oh  = '0;
        hit     = 1'b0;
`ifdef BIT_INDEX_DECODER_DUP_FLAG_EN
        dup_d   = dup_q;
`endif
        case (state_q)
            ACCUM: begin
                if (in_fire) begin
                    if (in_range) begin
                        bit_oh[in_idx] = 1'b1;
                        hit            = acc_q[in_idx];
                    end
                    // count tracks distinct bits, so a repeated index adds nothing
                    acc_d = acc_q | bit_oh;
                    cnt_d = cnt_q + (IW+1)'(in_range & ~hit);
`ifdef BIT_INDEX_DECODER_DUP_FLAG_EN
                    dup_d = dup_q | hit;
`endif
                    if (in_last) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    acc_d   = '0;
                    cnt_d   = '0;
`ifdef BIT_INDEX_DECODER_DUP_FLAG_EN
                    dup_d   = 1'b0;
`endif
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    assign out_valid = hold;
    assign out_vec   = hold ? acc_q : '0;
    assign out_count = hold ? cnt_q : '0;
`ifdef BIT_INDEX_DECODER_DUP_FLAG_EN
    assign out_dup   = hold & dup_q;
`endif

endmodule

// File: tb/tb_bit_index_decoder.sv
// Directed bench for bit_index_decoder at N=32; out_dup is checked when BIT_INDEX_DECODER_DUP_FLAG_EN is defined.
module tb_bit_index_decoder;

    localparam int N  = 32;
    localparam int IW = $clog2(N);

    logic          clk = 1'b0;
    logic          rstb;
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] in_idx;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_vec;
    logic [IW:0]   out_count;
`ifdef BIT_INDEX_DECODER_DUP_FLAG_EN
    logic          out_dup;
`endif

    int compared   = 0;
    int mismatched = 0;

    bit_index_decoder #(.N(N)) dut (
        .clk       (clk),
        .rstb      (rstb),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_idx    (in_idx),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_vec   (out_vec),
        .out_count (out_count)
`ifdef BIT_INDEX_DECODER_DUP_FLAG_EN
        ,
        .out_dup   (out_dup)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input int idx, input logic last);
        in_valid = 1'b1;
        in_idx   = IW'(idx);
        in_last  = last;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        rstb      = 1'b0;
        in_valid  = 1'b0;
        in_idx    = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        // reset state
        #3;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_vec", out_vec, 0);
        chk("rst_out_count", out_count, 0);
        step();
        step();
        chk("rst_held_in_ready", in_ready, 0);
        #3 rstb = 1'b1;
        step();
        chk("post_rst_in_ready", in_ready, 1);

        // idx 0,5,31 back-to-back
        out_ready = 1'b1;
        in_valid = 1'b1; in_last = 1'b0;
        in_idx = 5'd0;  step();
        chk("f1_accum_vec_hidden", out_vec, 0);
        chk("f1_accum_valid", out_valid, 0);
        in_idx = 5'd5;  step();
        in_idx = 5'd31; in_last = 1'b1; step();
        in_valid = 1'b0; in_last = 1'b0;
        chk("f1_out_valid", out_valid, 1);
        chk("f1_out_vec", out_vec, 64'h8000_0021);
        chk("f1_out_count", out_count, 3);
        chk("f1_in_ready_hold", in_ready, 0);
`ifdef BIT_INDEX_DECODER_DUP_FLAG_EN
        chk("f1_out_dup", out_dup, 0);
`endif
        step();
        chk("f1_in_ready_after", in_ready, 1);
        chk("f1_valid_after", out_valid, 0);
        chk("f1_vec_after", out_vec, 0);

        // repeated index 7,7
        out_ready = 1'b0;
        beat(7, 1'b0);
        beat(7, 1'b1);
        chk("f2_out_vec", out_vec, 64'h0000_0080);
        chk("f2_out_count", out_count, 1);
`ifdef BIT_INDEX_DECODER_DUP_FLAG_EN
        chk("f2_out_dup", out_dup, 1);
`endif
        out_ready = 1'b1;
        step();
        chk("f2_released", out_valid, 0);
`ifdef BIT_INDEX_DECODER_DUP_FLAG_EN
        chk("f2_dup_cleared", out_dup, 0);
`endif

        // backpressure: hold frame 3 while idx 9 waits
        out_ready = 1'b0;
        beat(3, 1'b1);
        in_valid = 1'b1; in_idx = 5'd9; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("f3_hold_in_ready", in_ready, 0);
            chk("f3_hold_vec", out_vec, 64'h0000_0008);
            chk("f3_hold_valid", out_valid, 1);
            step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("f3_handshake_in_ready", in_ready, 1);
        chk("f3_handshake_valid", out_valid, 0);
        step();
        in_valid = 1'b0;
        chk("f4_idx9_vec", out_vec, 64'h0000_0200);
        chk("f4_idx9_count", out_count, 1);
        out_ready = 1'b1;
        step();

        // reset during a partial frame, then during HOLD
        beat(1, 1'b0);
        beat(2, 1'b0);
        #2 rstb = 1'b0;
        #1;
        chk("rst_mid_in_ready", in_ready, 0);
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_vec", out_vec, 0);
        #2 rstb = 1'b1;
        step();
        out_ready = 1'b0;
        beat(6, 1'b1);
        chk("f5_hold_vec", out_vec, 64'h0000_0040);
        #2 rstb = 1'b0;
        #1;
        chk("rst_hold_valid", out_valid, 0);
        chk("rst_hold_vec", out_vec, 0);
        chk("rst_hold_count", out_count, 0);
        #2 rstb = 1'b1;
        step();
        chk("rst2_in_ready", in_ready, 1);
        out_ready = 1'b1;
        beat(4, 1'b1);
        chk("f6_out_vec", out_vec, 64'h0000_0010);
        chk("f6_out_count", out_count, 1);
        step();

        // gaps between beats 30 and 0
        beat(30, 1'b0);
        in_idx = 5'd12; in_last = 1'b1;
        step();
        step();
        chk("f7_gap_no_accept", out_valid, 0);
        beat(0, 1'b1);
        chk("f7_out_vec", out_vec, 64'h4000_0001);
        chk("f7_out_count", out_count, 2);
        step();

        // all 32 indices
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            beat(i, (i == N-1));
        end
        chk("f8_out_vec", out_vec, 64'hFFFF_FFFF);
        chk("f8_out_count", out_count, 32);
        out_ready = 1'b1;
        step();
        chk("f8_released", in_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/bit_index_decoder.md
BIT_INDEX_DECODER -- requirements
Module: bit_index_decoder

Interface
REQ-001 SHALL have parameter N, default 32: vector width in bits (N >= 2); IW = $clog2(N).
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rstb  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  index beat valid.
REQ-005 SHALL have port in_ready  output  1  block can accept an index beat.
REQ-006 SHALL have port in_idx  input  IW  bit index to set.
REQ-007 SHALL have port in_last  input  1  beat closes the current frame.
REQ-008 SHALL have port out_valid  output  1  rebuilt vector available.
REQ-009 SHALL have port out_ready  input  1  downstream accepts the vector.
REQ-010 SHALL have port out_vec  output  N  rebuilt vector.
REQ-011 SHALL have port out_count  output  IW+1  number of ones in out_vec.

Function
REQ-012 SHALL implement a two-state FSM: ACCUM (collecting beats) and HOLD (presenting the vector).
REQ-013 SHALL drive in_ready=1 in ACCUM and in_ready=0 in HOLD; in_ready is a function of state only, with no dependence on in_valid.
REQ-014 SHALL accept a beat when in_valid&in_ready; on acceptance, accumulator bit in_idx is set (OR), and all other bits are unchanged.
REQ-015 SHALL silently drop the bit set for an accepted beat with in_idx >= N (possible only when N is not a power of 2); in_last of that beat is still honoured.
REQ-016 SHALL, on acceptance of a beat with in_last=1, move to HOLD; out_valid=1 on the next cycle (1-cycle latency), and out_vec includes the final beat's bit.
REQ-017 SHALL merge a repeated index within a frame (bit stays 1); out_count counts distinct set bits.
REQ-018 SHALL keep out_vec, out_count and out_valid stable in HOLD until out_valid&out_ready.
REQ-019 SHALL, on the output handshake, clear the accumulator and count and return to ACCUM; in_ready=1 on the following cycle.
REQ-020 SHALL drive out_vec=0 and out_count=0 while in ACCUM (the partial frame is not visible).
REQ-021 SHALL register out_count alongside out_vec (no combinational popcount path to outputs in HOLD); its range is 0..N.
REQ-022 SHALL treat a frame consisting of a single beat with in_last=1 as legal.
REQ-023 SHALL ignore in_valid in HOLD; no beat is consumed.

Reset
REQ-024 SHALL, while rstb=0, force state=ACCUM, accumulator=0, out_vec=0, out_count=0, out_valid=0 and in_ready=0, asynchronously.
REQ-025 SHALL drive in_ready=1 from the first clock edge after rstb deasserts.
REQ-026 SHALL discard a partial frame or held vector when reset asserts mid-operation; no output handshake occurs for it.

Configuration
REQ-027 SHALL, with macro BIT_INDEX_DECODER_DUP_FLAG_EN defined, add port out_dup  output  1, which is valid with out_vec and is 1 iff any accepted in-range beat of the frame targeted an already-set bit; it is 0 in ACCUM and reset.
REQ-028 SHALL, without BIT_INDEX_DECODER_DUP_FLAG_EN, omit out_dup and merge duplicates silently with no other behavioural change.

Verification (N=32)
REQ-029 SHALL cover: beats idx 0,5,31(last) back-to-back, out_ready=1 -> out_valid 1 cycle after last, out_vec=0x80000021, out_count=3, in_ready high next cycle.
REQ-030 SHALL cover: beats 7,7(last) -> out_vec=0x00000080, out_count=1, out_dup=1 when DUP_FLAG_EN is defined.
REQ-031 SHALL cover: frame 3(last) with out_ready=0 for 5 cycles and in_valid held with idx 9 -> in_ready=0 and out_vec=0x00000008 stable throughout; idx 9 is accepted only after the handshake.
REQ-032 SHALL cover: beats 1,2 then rstb pulsed low asynchronously -> all outputs 0 immediately; a next frame 4(last) yields 0x00000010, count 1.
REQ-033 SHALL cover: in_valid toggling with gaps between beats 30,0(last) -> out_vec=0x40000001, out_count=2, and no beat is lost or doubled.
REQ-034 SHALL cover: all 32 indices in one frame -> out_vec=0xFFFFFFFF, out_count=32.
